// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and select sequencer for a shared 4:1 one-bit mux.
// Grants one of four requesters at a time, holds each grant for at most
// MAX_HOLD cycles, and drives the mux selects plus a registered data tap.
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] din,
    output logic [3:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic       dout,
    output logic       dout_vld,
    output logic       busy
);

    localparam int unsigned      CNT_W     = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [1:0]       ptr;
    logic [1:0]       ptr_n;
    logic [1:0]       sel;
    logic [1:0]       sel_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [3:0]       gnt_n;

    logic [1:0]       rel_start;
    logic [2:0]       pick_idle;
    logic [2:0]       pick_rel;
    logic             hold;

    // First set request at or after 'start', wrapping 3->0.
    // Result is {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!res[2] && r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // The current owner is always the select value, since selects only
    // move on a new grant; after release the owner drops to lowest priority.
    assign rel_start = sel + 2'd1;
    assign pick_idle = rr_pick(req, ptr);
    assign pick_rel  = rr_pick(req, rel_start);
    assign hold      = req[sel] && (cnt != '0);

    // Next-state, pointer, counter, grant and select decisions.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        sel_n   = sel;
        cnt_n   = cnt;
        gnt_n   = gnt;
        unique case (state)
            IDLE: begin
                if (pick_idle[2]) begin
                    state_n = GRANT;
                    sel_n   = pick_idle[1:0];
                    gnt_n   = 4'b0001 << pick_idle[1:0];
                    cnt_n   = HOLD_LOAD;
                end else begin
                    gnt_n = '0;
                end
            end
            GRANT: begin
                if (hold) begin
                    cnt_n = cnt - CNT_W'(1);
                end else begin
                    ptr_n = rel_start;
                    if (pick_rel[2]) begin
                        sel_n = pick_rel[1:0];
                        gnt_n = 4'b0001 << pick_rel[1:0];
                        cnt_n = HOLD_LOAD;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            sel   <= '0;
            cnt   <= '0;
            gnt   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            sel   <= sel_n;
            cnt   <= cnt_n;
            gnt   <= gnt_n;
        end
    end

    // Registered mux tap: samples the input chosen by the current selects.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout     <= 1'b0;
            dout_vld <= 1'b0;
        end else begin
            dout     <= din[sel];
            dout_vld <= |gnt;
        end
    end

    assign s0   = sel[0];
    assign s1   = sel[1];
    assign busy = |gnt;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: four instances with different hold limits
// share one stimulus stream and are compared against a cycle-level model.
module tb_mux4_rr_arbiter;

    localparam int HOLD [4] = '{1, 2, 3, 8};

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] din;

    logic [3:0] gnt_w      [4];
    logic       s0_w       [4];
    logic       s1_w       [4];
    logic       dout_w     [4];
    logic       dout_vld_w [4];
    logic       busy_w     [4];

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: owner index (-1 when idle), cycles the owner has
    // seen its grant, rotation start, last select, registered data tap.
    int   m_owner [4];
    int   m_held  [4];
    int   m_ptr   [4];
    int   m_sel   [4];
    logic m_dout  [4];
    logic m_vld   [4];

    mux4_rr_arbiter #(.MAX_HOLD(1)) u_h1 (
        .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt_w[0]), .s0(s0_w[0]), .s1(s1_w[0]),
        .dout(dout_w[0]), .dout_vld(dout_vld_w[0]), .busy(busy_w[0]));
    mux4_rr_arbiter #(.MAX_HOLD(2)) u_h2 (
        .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt_w[1]), .s0(s0_w[1]), .s1(s1_w[1]),
        .dout(dout_w[1]), .dout_vld(dout_vld_w[1]), .busy(busy_w[1]));
    mux4_rr_arbiter #(.MAX_HOLD(3)) u_h3 (
        .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt_w[2]), .s0(s0_w[2]), .s1(s1_w[2]),
        .dout(dout_w[2]), .dout_vld(dout_vld_w[2]), .busy(busy_w[2]));
    mux4_rr_arbiter #(.MAX_HOLD(8)) u_h8 (
        .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt_w[3]), .s0(s0_w[3]), .s1(s1_w[3]),
        .dout(dout_w[3]), .dout_vld(dout_vld_w[3]), .busy(busy_w[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // First requester found walking from 'start' upward, modulo 4.
    function automatic int rr_first(input logic [3:0] r, input int start);
        for (int j = 0; j < 4; j++) begin
            int c;
            c = (start + j) % 4;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic void model_edge(input int k);
        int w;
        if (rst) begin
            m_owner[k] = -1;
            m_held[k]  = 0;
            m_ptr[k]   = 0;
            m_sel[k]   = 0;
            m_dout[k]  = 1'b0;
            m_vld[k]   = 1'b0;
            return;
        end
        m_dout[k] = din[m_sel[k]];
        m_vld[k]  = (m_owner[k] >= 0);
        if (m_owner[k] < 0) begin
            w = rr_first(req, m_ptr[k]);
            if (w >= 0) begin
                m_owner[k] = w;
                m_sel[k]   = w;
                m_held[k]  = 1;
            end
        end else if (req[m_owner[k]] && m_held[k] < HOLD[k]) begin
            m_held[k]++;
        end else begin
            m_ptr[k] = (m_owner[k] + 1) % 4;
            w = rr_first(req, m_ptr[k]);
            m_owner[k] = w;
            if (w >= 0) begin
                m_sel[k]  = w;
                m_held[k] = 1;
            end else begin
                m_held[k] = 0;
            end
        end
    endfunction

    task automatic check_inst(input int k);
        logic [3:0] eg;
        logic [1:0] es;
        eg = (m_owner[k] >= 0) ? 4'(1 << m_owner[k]) : 4'b0000;
        es = 2'(m_sel[k]);
        check($sformatf("gnt h%0d", HOLD[k]), 32'(gnt_w[k]), 32'(eg));
        check($sformatf("sel h%0d", HOLD[k]), 32'({s1_w[k], s0_w[k]}), 32'(es));
        check($sformatf("dout h%0d", HOLD[k]), 32'(dout_w[k]), 32'(m_dout[k]));
        check($sformatf("dout_vld h%0d", HOLD[k]), 32'(dout_vld_w[k]), 32'(m_vld[k]));
        check($sformatf("busy h%0d", HOLD[k]), 32'(busy_w[k]), 32'(m_owner[k] >= 0));
    endtask

    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 4; k++) model_edge(k);
        #1;
        for (int k = 0; k < 4; k++) check_inst(k);
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b1111;
        din = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            m_owner[k] = -1; m_held[k] = 0; m_ptr[k] = 0;
            m_sel[k] = 0; m_dout[k] = 1'b0; m_vld[k] = 1'b0;
        end

        // Reset held for two cycles with all requests asserted.
        step();
        step();
        for (int k = 0; k < 4; k++) check("reset gnt", 32'(gnt_w[k]), 32'h0);
        rst = 1'b0;
        step();
        for (int k = 0; k < 4; k++) check("first grant", 32'(gnt_w[k]), 32'h1);

        req = 4'b0000;
        step();
        step();

        // Single requester 2 with din routing a one through input 2.
        din = 4'b0100;
        req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            step();
            check("single gnt", 32'(gnt_w[3]), 32'h4);
            check("single sel", 32'({s1_w[3], s0_w[3]}), 32'h2);
        end
        req = 4'b0000;
        step();
        check("single gnt off", 32'(gnt_w[3]), 32'h0);
        check("single dout", 32'(dout_w[3]), 32'h1);
        check("single vld", 32'(dout_vld_w[3]), 32'h1);
        step();

        // Full contention rotation.
        din = 4'b1010;
        req = 4'b1111;
        repeat (16) step();
        req = 4'b0000;
        step();
        step();

        // Sole owner re-granted on expiry.
        req = 4'b0010;
        repeat (10) begin
            step();
            for (int k = 0; k < 4; k++) check("sole busy", 32'(busy_w[k]), 32'h1);
        end
        req = 4'b0000;
        step();
        step();

        // Release with a pending request: owner 1 drops, 3 takes over.
        req = 4'b0010;
        step();
        step();
        req = 4'b1010;
        step();
        step();
        req = 4'b1000;
        step();
        check("handover gnt", 32'(gnt_w[3]), 32'h8);
        check("handover sel", 32'({s1_w[3], s0_w[3]}), 32'h3);
        req = 4'b0000;
        step();
        step();

        // Reset in the middle of a grant held by requester 2.
        req = 4'b0100;
        repeat (3) step();
        rst = 1'b1;
        step();
        for (int k = 0; k < 4; k++) check("midreset gnt", 32'(gnt_w[k]), 32'h0);
        rst = 1'b0;
        req = 4'b0101;
        step();
        for (int k = 0; k < 4; k++) check("post reset gnt", 32'(gnt_w[k]), 32'h1);

        // Randomised traffic with occasional resets.
        repeat (3000) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            din = 4'($urandom);
            rst = ($urandom_range(0, 96) == 0);
            step();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and sequencer for the shared 4:1 one-bit mux datapath. It arbitrates between four requesters and drives the mux selects `s0`/`s1` to the granted input. Each grant is held for a bounded number of cycles. The selected bit is registered out with a valid flag. The block sits directly in front of the 4:1 mux and owns its select lines: no other logic drives `s0`/`s1`.

## Interface
Parameters:
- `MAX_HOLD`, default 8: maximum consecutive cycles one requester may hold the grant. Legal range 1..255.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `req`, input, 4: request per requester; bit n requests input In.
- `din`, input, 4: mux data inputs; bit n corresponds to In (I0..I3).
- `gnt`, output, 4: one-hot grant, registered; all zero when idle.
- `s0`, output, 1: mux select LSB, registered.
- `s1`, output, 1: mux select MSB, registered.
- `dout`, output, 1: registered mux output, `din[{s1,s0}]`.
- `dout_vld`, output, 1: `dout` carries a granted sample.
- `busy`, output, 1: high whenever `gnt` is non-zero.

## Operation
- Reset values: `gnt`=0000, `s0`=0, `s1`=0, `dout`=0, `dout_vld`=0, `busy`=0. Internally: state=IDLE, rr pointer=0, hold counter=0.
- States: IDLE and GRANT.
- IDLE:
  - If `req` is non-zero, pick a winner by round-robin. The search starts at the pointer and wraps 3→0.
  - Register `gnt` = one-hot(winner) and `{s1,s0}` = winner.
  - Load the hold counter with `MAX_HOLD-1` and go to GRANT.
  - If `req` is zero, stay in IDLE with `gnt`=0. `{s1,s0}` keeps its last value.
- GRANT, with owner = granted index:
  - Hold while `req[owner]`=1 and counter>0; decrement the counter each cycle.
  - Release when `req[owner]`=0 or counter=0.
  - On release, the pointer becomes (owner+1) mod 4, so the owner now has the lowest priority.
  - In the same cycle as release, re-arbitrate over the current `req`:
    - Any eligible request: new grant back-to-back with no idle cycle, counter reloaded, stay in GRANT.
    - None: go to IDLE with `gnt`=0.
- An owner whose hold expired with `req` still high is eligible again only at lowest priority. If it is the sole requester, it is regranted back-to-back.
- `{s1,s0}` changes only on a new grant. It is stable for the whole grant.
- Datapath: each cycle, `dout` <= `din[{s1,s0}]` and `dout_vld` <= (`gnt`≠0).
- Counter: `$clog2(MAX_HOLD+1)` bits minimum, 8 bits allowed. It never underflows.
- `MAX_HOLD`=1: every grant lasts exactly one cycle, so the grant rotates every cycle among active requesters.
- `rst` during GRANT: at the next edge, all outputs and state return to reset values. No partial release or pointer update takes place.

## Timing
- Request to grant: `req` sampled at edge t gives `gnt`/`s0`/`s1` valid after edge t, i.e. 1-cycle latency.
- Release: the first edge that samples `req[owner]`=0 updates `gnt` at that same edge. The owner therefore sees `gnt` for exactly one cycle after its last cycle of `req`=1 before dropping.
- Grant duration: at most `MAX_HOLD` cycles, at least 1 cycle.
- Data: `dout` lags the select by 1 cycle. `dout_vld` lags `gnt` by 1 cycle.
- `busy` is equal to the OR-reduce of `gnt`, with the same timing as `gnt`.
- Requests arriving simultaneously are resolved purely by pointer order, with no fixed priority.

## Test plan
- Reset: apply `rst`=1 for 2 cycles with `req`=1111 → `gnt`=0000, `s0`=`s1`=0, `dout_vld`=0. First grant after release goes to requester 0.
- Single requester: `req`=0100 for 3 cycles, then 0000, with `MAX_HOLD`=8 and `din`=0100.
  - Expect `gnt`=0100, `s1`=1, `s0`=0 for 3 cycles.
  - Expect `dout`=1 and `dout_vld`=1 one cycle later, then `gnt`=0000.
- Full contention: `req`=1111 held, `MAX_HOLD`=2 → grants 0,1,2,3,0,…, each 2 cycles, with no gap between them.
- Sole owner expiry: `req`=0010 held, `MAX_HOLD`=3 → `gnt`=0010 continuously, with the counter reloading every 3 cycles and `busy` never dropping.
- Release with pending request: owner 1 holds and `req[3]` rises; owner 1 then drops → `gnt`=1000 at the release edge with no idle cycle, `{s1,s0}`=11.
- Reset mid-grant: assert `rst` for 1 cycle while owner 2 holds with counter 5 → all outputs return to reset values at the next edge. With `req`=0101 afterwards, the next grant goes to 0, since the pointer was reset.
